// File: rtl/input_pkg.sv
// Shared definitions for the player-input front end: command codes, key indices
// and the seed LFSR constants (used when INPUT_CONTROLLER_SEED_EN is defined).
package input_pkg;

  typedef enum logic [1:0] {
    HIT     = 2'd0,
    STAND   = 2'd1,
    DEAL    = 2'd2,
    NEWGAME = 2'd3
  } cmd_t;

  localparam int unsigned KEY_HIT     = 0;
  localparam int unsigned KEY_STAND   = 1;
  localparam int unsigned KEY_DEAL    = 2;
  localparam int unsigned KEY_NEWGAME = 3;

  localparam logic [15:0] LFSR_RESET = 16'hACE1;
  // Right-shifting Galois form of taps 16,14,13,11
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;

  function automatic logic [15:0] lfsrNext(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// One push-button: SYNC_STAGES-deep synchroniser followed by a four-state debounce
// FSM that reports the debounced level and a one-cycle strobe on each accepted press.
module key_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_n,
  output logic held,
  output logic press_strobe
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] TERMINAL = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {RELEASED, PRESS_WAIT, HELD, RELEASE_WAIT} dbState_t;

  dbState_t               state;
  logic [SYNC_STAGES-1:0] syncQ;
  logic [CW-1:0]          count;
  logic                   level;

  assign level = ~syncQ[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syncQ        <= '1;
      state        <= RELEASED;
      count        <= '0;
      held         <= 1'b0;
      press_strobe <= 1'b0;
    end else begin
      syncQ        <= {syncQ[SYNC_STAGES-2:0], raw_n};
      press_strobe <= 1'b0;
      case (state)
        RELEASED: if (level) begin
          state <= PRESS_WAIT;
          count <= '0;
        end
        PRESS_WAIT: begin
          if (!level) begin
            state <= RELEASED;
          end else if (count == TERMINAL) begin
            state        <= HELD;
            held         <= 1'b1;
            press_strobe <= 1'b1;
          end else begin
            count <= count + 1'b1;
          end
        end
        HELD: if (!level) begin
          state <= RELEASE_WAIT;
          count <= '0;
        end
        RELEASE_WAIT: begin
          if (level) begin
            state <= HELD;
          end else if (count == TERMINAL) begin
            state <= RELEASED;
            held  <= 1'b0;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: state <= RELEASED;
      endcase
    end
  end

endmodule

// File: rtl/input_controller.sv
// Debounces KEY[3:0] and turns each accepted press into a game command held in a
// one-entry valid/ready buffer. Define INPUT_CONTROLLER_SEED_EN for the seed LFSR outputs.
module input_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  key_n,
  input  logic        cmd_ready,
  output logic        cmd_valid,
  output logic [1:0]  cmd,
  output logic        cmd_dropped,
  output logic [3:0]  keys_held
`ifdef INPUT_CONTROLLER_SEED_EN
  ,
  output logic [15:0] seed,
  output logic        seed_valid
`endif
);

  import input_pkg::*;

  logic [3:0] strobe;
  logic       anyStrobe;
  logic       multiStrobe;
  logic       transfer;
  cmd_t       winner;
  cmd_t       pendingCmd;

  for (genvar k = 0; k < 4; k++) begin : gKey
    key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) uDebouncer (
      .clk         (clk),
      .rst_n       (rst_n),
      .raw_n       (key_n[k]),
      .held        (keys_held[k]),
      .press_strobe(strobe[k])
    );
  end

  always_comb begin
    anyStrobe   = |strobe;
    multiStrobe = (strobe & (strobe - 4'd1)) != 4'd0;
    winner      = HIT;
    if (strobe[KEY_NEWGAME])    winner = NEWGAME;
    else if (strobe[KEY_DEAL])  winner = DEAL;
    else if (strobe[KEY_STAND]) winner = STAND;
  end

  assign transfer = cmd_valid && cmd_ready;
  assign cmd      = pendingCmd;

  // A strobe that cannot load (buffer full, no transfer) is a drop, including the
  // NEWGAME overwrite, which replaces the pending entry and still flags the loss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid   <= 1'b0;
      pendingCmd  <= HIT;
      cmd_dropped <= 1'b0;
    end else begin
      if (transfer && pendingCmd == NEWGAME) cmd_dropped <= 1'b0;
      if (anyStrobe) begin
        if (!cmd_valid || transfer) begin
          pendingCmd <= winner;
          cmd_valid  <= 1'b1;
        end else if (winner == NEWGAME && pendingCmd != NEWGAME) begin
          pendingCmd <= NEWGAME;
        end
        if (multiStrobe || (cmd_valid && !transfer)) cmd_dropped <= 1'b1;
      end else if (transfer) begin
        cmd_valid <= 1'b0;
      end
    end
  end

`ifdef INPUT_CONTROLLER_SEED_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr       <= LFSR_RESET;
      seed       <= '0;
      seed_valid <= 1'b0;
    end else begin
      lfsr       <= lfsrNext(lfsr);
      seed_valid <= transfer && pendingCmd == DEAL;
      if (transfer && pendingCmd == DEAL) seed <= lfsr;
    end
  end
`endif

endmodule

// File: tb/tb_input_controller.sv
// Self-checking bench for input_controller with a run-length debounce reference model.
module tb_input_controller;

  localparam int unsigned D = 4;
  localparam int unsigned S = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key_n = 4'hF;
  logic       cmd_ready = 1'b0;
  logic       cmd_valid;
  logic [1:0] cmd;
  logic       cmd_dropped;
  logic [3:0] keys_held;
`ifdef INPUT_CONTROLLER_SEED_EN
  logic [15:0] seed;
  logic        seed_valid;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  input_controller #(.DEBOUNCE_CYCLES(D), .SYNC_STAGES(S)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_n      (key_n),
    .cmd_ready  (cmd_ready),
    .cmd_valid  (cmd_valid),
    .cmd        (cmd),
    .cmd_dropped(cmd_dropped),
    .keys_held  (keys_held)
`ifdef INPUT_CONTROLLER_SEED_EN
    ,
    .seed       (seed),
    .seed_valid (seed_valid)
`endif
  );

  // Reference model: a key's level, seen S cycles late, must differ from the
  // debounced level on D+1 consecutive samples to flip it; rising flips are presses.
  logic [3:0] pipe [S];
  logic [3:0] mHeld, mStrobe;
  int         run [4];
  logic       mValid, mDropped, mSeedValid;
  logic [1:0] mCmd;

  always @(posedge clk or negedge rst_n) begin : model
    logic [3:0] lvl, nHeld, nStrobe;
    logic       nValid, nDropped, xfer;
    logic [1:0] nCmd;
    int         nRun [4];
    int         win, nPress;
    if (!rst_n) begin
      for (int i = 0; i < S; i++) pipe[i] <= 4'hF;
      for (int k = 0; k < 4; k++) run[k] <= 0;
      mHeld <= '0; mStrobe <= '0; mValid <= 1'b0; mCmd <= 2'd0;
      mDropped <= 1'b0; mSeedValid <= 1'b0;
    end else begin
      nValid = mValid; nCmd = mCmd; nDropped = mDropped; nHeld = mHeld; nRun = run;
      xfer = mValid && cmd_ready;
      if (xfer && mCmd == 2'd3) nDropped = 1'b0;
      nPress = $countones(mStrobe);
      win = 0;
      for (int k = 0; k < 4; k++) if (mStrobe[k]) win = k;
      if (nPress > 0) begin
        if (nPress > 1) nDropped = 1'b1;
        if (!mValid || xfer) begin
          nCmd = 2'(win); nValid = 1'b1;
        end else begin
          nDropped = 1'b1;
          if (win == 3) nCmd = 2'd3;
        end
      end else if (xfer) begin
        nValid = 1'b0;
      end
      lvl = ~pipe[0];
      nStrobe = '0;
      for (int k = 0; k < 4; k++) begin
        if (lvl[k] != nHeld[k]) nRun[k] = nRun[k] + 1; else nRun[k] = 0;
        if (nRun[k] == int'(D) + 1) begin
          nHeld[k] = ~nHeld[k];
          nRun[k]  = 0;
          if (nHeld[k]) nStrobe[k] = 1'b1;
        end
      end
      for (int i = 0; i < S - 1; i++) pipe[i] <= pipe[i+1];
      pipe[S-1] <= key_n;
      mValid <= nValid; mCmd <= nCmd; mDropped <= nDropped; mHeld <= nHeld;
      mStrobe <= nStrobe; run <= nRun; mSeedValid <= xfer && mCmd == 2'd2;
    end
  end

  logic [7:0] obsVec, expVec;
  assign obsVec = {cmd_valid, cmd_valid ? cmd : 2'b00, cmd_dropped, keys_held};
  assign expVec = {mValid, mValid ? mCmd : 2'b00, mDropped, mHeld};

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({cmd_valid, cmd, cmd_dropped, keys_held} !== 8'h00) begin
      errors++;
      $display("FAIL reset_values: got %b expected %b", {cmd_valid, cmd, cmd_dropped, keys_held}, 8'h00);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (obsVec !== expVec) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: got %b expected %b", c, obsVec, expVec);
      end
    end
  endtask

  task automatic test_hit_press();
    int lat = -1;
    int hits = 0;
    cmd_ready = 1'b1;
    key_n = 4'b1110;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      checks++;
      if (obsVec !== expVec) begin
        errors++;
        $display("FAIL hit_press cycle %0d: got %b expected %b", c, obsVec, expVec);
      end
      if (cmd_valid && lat < 0) lat = c - 1;
      if (cmd_valid && cmd === 2'd0) hits++;
    end
    checks++;
    if (lat != int'(S + D + 1)) begin
      errors++;
      $display("FAIL hit_latency: got %0d expected %0d", lat, S + D + 1);
    end
    checks++;
    if (hits != 1) begin
      errors++;
      $display("FAIL hit_single: got %0d commands expected 1", hits);
    end
    key_n = 4'hF;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (obsVec !== expVec) begin
        errors++;
        $display("FAIL hit_release cycle %0d: got %b expected %b", c, obsVec, expVec);
      end
    end
  endtask

  task automatic test_bounce();
    int stands = 0;
    cmd_ready = 1'b1;
    for (int c = 0; c < 32; c++) begin
      key_n[1] = (c < 12) ? (((c / 2) % 2) == 1) : 1'b0;
      @(negedge clk);
      checks++;
      if (obsVec !== expVec) begin
        errors++;
        $display("FAIL bounce cycle %0d: got %b expected %b", c, obsVec, expVec);
      end
      if (cmd_valid && cmd === 2'd1) stands++;
    end
    checks++;
    if (stands != 1) begin
      errors++;
      $display("FAIL bounce_single: got %0d STAND expected 1", stands);
    end
    key_n = 4'hF;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (obsVec !== expVec) begin
        errors++;
        $display("FAIL bounce_release cycle %0d: got %b expected %b", c, obsVec, expVec);
      end
    end
  endtask

  task automatic test_backpressure();
    int deals = 0;
    int hits = 0;
    cmd_ready = 1'b0;
    for (int c = 0; c < 36; c++) begin
      key_n = (c < 12) ? 4'b1011 : (c < 24) ? 4'b1110 : 4'hF;
      @(negedge clk);
      checks++;
      if (obsVec !== expVec) begin
        errors++;
        $display("FAIL backpressure cycle %0d: got %b expected %b", c, obsVec, expVec);
      end
    end
    checks++;
    if ({cmd_valid, cmd, cmd_dropped} !== 4'b1101) begin
      errors++;
      $display("FAIL backpressure_hold: got %b expected %b", {cmd_valid, cmd, cmd_dropped}, 4'b1101);
    end
    cmd_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (cmd_valid && cmd === 2'd2) deals++;
      if (cmd_valid && cmd === 2'd0) hits++;
      @(negedge clk);
      checks++;
      if (obsVec !== expVec) begin
        errors++;
        $display("FAIL backpressure_drain cycle %0d: got %b expected %b", c, obsVec, expVec);
      end
    end
    checks++;
    if (deals != 1 || hits != 0) begin
      errors++;
      $display("FAIL backpressure_result: got deal=%0d hit=%0d expected deal=1 hit=0", deals, hits);
    end
  endtask

  task automatic test_newgame_override();
    cmd_ready = 1'b0;
    for (int c = 0; c < 24; c++) begin
      key_n = (c < 10) ? 4'b1110 : 4'b0111;
      @(negedge clk);
      checks++;
      if (obsVec !== expVec) begin
        errors++;
        $display("FAIL newgame cycle %0d: got %b expected %b", c, obsVec, expVec);
      end
    end
    checks++;
    if ({cmd_valid, cmd, cmd_dropped} !== 4'b1111) begin
      errors++;
      $display("FAIL newgame_overwrite: got %b expected %b", {cmd_valid, cmd, cmd_dropped}, 4'b1111);
    end
    cmd_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({cmd_valid, cmd_dropped} !== 2'b00) begin
      errors++;
      $display("FAIL newgame_accept: got %b expected %b", {cmd_valid, cmd_dropped}, 2'b00);
    end
    key_n = 4'hF;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (obsVec !== expVec) begin
        errors++;
        $display("FAIL newgame_release cycle %0d: got %b expected %b", c, obsVec, expVec);
      end
    end
  endtask

  task automatic test_simultaneous();
    int stands = 0;
    int hits = 0;
    cmd_ready = 1'b1;
    key_n = 4'b1100;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      checks++;
      if (obsVec !== expVec) begin
        errors++;
        $display("FAIL simultaneous cycle %0d: got %b expected %b", c, obsVec, expVec);
      end
      if (cmd_valid && cmd === 2'd1) stands++;
      if (cmd_valid && cmd === 2'd0) hits++;
    end
    checks++;
    if (stands != 1 || hits != 0 || cmd_dropped !== 1'b1) begin
      errors++;
      $display("FAIL simultaneous_result: got stand=%0d hit=%0d dropped=%b expected 1 0 1", stands, hits, cmd_dropped);
    end
    key_n = 4'hF;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (obsVec !== expVec) begin
        errors++;
        $display("FAIL simultaneous_release cycle %0d: got %b expected %b", c, obsVec, expVec);
      end
    end
  endtask

  task automatic test_async_reset();
    bit pending = 0;
    bit reissued = 0;
    cmd_ready = 1'b0;
    key_n = 4'b1011;
    for (int c = 0; c < 30 && !pending; c++) begin
      @(negedge clk);
      checks++;
      if (obsVec !== expVec) begin
        errors++;
        $display("FAIL async_pre cycle %0d: got %b expected %b", c, obsVec, expVec);
      end
      pending = cmd_valid;
    end
    checks++;
    if (!pending) begin
      errors++;
      $display("FAIL async_pending: got valid=0 expected valid=1 within 30 cycles");
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({cmd_valid, keys_held} !== 5'b0) begin
      errors++;
      $display("FAIL async_clear: got %b expected %b", {cmd_valid, keys_held}, 5'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cmd_ready = 1'b1;
    for (int c = 0; c < 3 * int'(S + D) + 10; c++) begin
      @(negedge clk);
      checks++;
      if (obsVec !== expVec) begin
        errors++;
        $display("FAIL async_post cycle %0d: got %b expected %b", c, obsVec, expVec);
      end
      if (cmd_valid && cmd === 2'd2) reissued = 1;
    end
    checks++;
    if (!reissued) begin
      errors++;
      $display("FAIL async_reissue: got no DEAL expected one DEAL after reset");
    end
    key_n = 4'hF;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (obsVec !== expVec) begin
        errors++;
        $display("FAIL async_release cycle %0d: got %b expected %b", c, obsVec, expVec);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      for (int k = 0; k < 4; k++) if ($urandom_range(5) == 0) key_n[k] = ~key_n[k];
      cmd_ready = ($urandom_range(2) != 0);
      @(negedge clk);
      checks++;
      if (obsVec !== expVec) begin
        errors++;
        $display("FAIL random cycle %0d: got %b expected %b", c, obsVec, expVec);
      end
`ifdef INPUT_CONTROLLER_SEED_EN
      checks++;
      if (seed_valid !== mSeedValid || (seed_valid && seed === 16'h0)) begin
        errors++;
        $display("FAIL random_seed cycle %0d: got valid=%b seed=%h expected valid=%b nonzero", c, seed_valid, seed, mSeedValid);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_hit_press();
    test_bounce();
    test_backpressure();
    test_newgame_override();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
